// File: rtl/bch_dec_arbiter.sv
// bch_dec_arbiter: shares one pipelined BCH(15,7) decoder between two requester channels.
//
// Codewords from channel 0/1 are arbitrated round-robin, issued at most one per cycle
// into the decoder through the registered dec_codeword. A {valid, id} tag pipeline,
// one stage longer than the decoder latency, follows each word. The tag that reaches
// the last stage routes the decoder result to the channel that issued it.
//
// Ports:
//   clk, rst (synchronous, active-low), enable (0 blocks new grants, in-flight drain)
//   req0_valid/req0_ready/req0_codeword, req1_valid/req1_ready/req1_codeword
//   dec_codeword (to decoder), dec_corrected/dec_error_flag (from decoder)
//   rsp0_valid/rsp0_data/rsp0_error, rsp1_valid/rsp1_data/rsp1_error (no backpressure)
//   busy (any word in flight or response strobe pending)
//
// Optional feature, macro BCH_ARB_STATS_EN: adds stat_clr input plus saturating 16-bit
// stat_words (responses emitted) and stat_errors (responses with error=1) counters.

module bch_dec_arbiter #(
    parameter int unsigned DEC_LATENCY = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [14:0] req0_codeword,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [14:0] req1_codeword,
    output logic [14:0] dec_codeword,
    input  logic [14:0] dec_corrected,
    input  logic        dec_error_flag,
    output logic        rsp0_valid,
    output logic [14:0] rsp0_data,
    output logic        rsp0_error,
    output logic        rsp1_valid,
    output logic [14:0] rsp1_data,
    output logic        rsp1_error,
`ifdef BCH_ARB_STATS_EN
    input  logic        stat_clr,
    output logic [15:0] stat_words,
    output logic [15:0] stat_errors,
`endif
    output logic        busy
);

    localparam int unsigned Stages = DEC_LATENCY + 1;

    logic              last_grant;
    logic              grant;
    logic              xfer;
    logic [Stages-1:0] tag_valid;
    logic [Stages-1:0] tag_id;
    logic              out_valid;
    logic              out_id;

    // A lone requester always wins; under contention the channel that did not win last.
    // With nobody requesting, grant points at the next channel in rotation.
    always_comb begin
        grant = ~last_grant;
        if (req0_valid && !req1_valid) begin
            grant = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            grant = 1'b1;
        end
    end

    assign req0_ready = rst && enable && !grant;
    assign req1_ready = rst && enable && grant;
    assign xfer       = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    assign out_valid  = tag_valid[Stages-1];
    assign out_id     = tag_id[Stages-1];

    // Issue side and tag pipeline; the pipeline never stalls.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_grant   <= 1'b1;
            dec_codeword <= '0;
            tag_valid    <= '0;
            tag_id       <= '0;
        end else begin
            for (int i = 1; i < int'(Stages); i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_id[i]    <= tag_id[i-1];
            end
            tag_valid[0] <= xfer;
            tag_id[0]    <= grant;
            if (xfer) begin
                dec_codeword <= grant ? req1_codeword : req0_codeword;
                last_grant   <= grant;
            end
        end
    end

    // Response side: decoder output is aligned with the last tag stage.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rsp0_valid <= 1'b0;
            rsp0_data  <= '0;
            rsp0_error <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp1_data  <= '0;
            rsp1_error <= 1'b0;
        end else begin
            rsp0_valid <= out_valid && !out_id;
            rsp1_valid <= out_valid && out_id;
            if (out_valid && !out_id) begin
                rsp0_data  <= dec_corrected;
                rsp0_error <= dec_error_flag;
            end
            if (out_valid && out_id) begin
                rsp1_data  <= dec_corrected;
                rsp1_error <= dec_error_flag;
            end
        end
    end

    assign busy = (|tag_valid) || rsp0_valid || rsp1_valid;

`ifdef BCH_ARB_STATS_EN
    // Counters advance on the edge that raises a response strobe; clear beats increment.
    always_ff @(posedge clk) begin
        if (!rst || stat_clr) begin
            stat_words  <= '0;
            stat_errors <= '0;
        end else if (out_valid) begin
            if (stat_words != 16'hFFFF) begin
                stat_words <= stat_words + 16'd1;
            end
            if (dec_error_flag && (stat_errors != 16'hFFFF)) begin
                stat_errors <= stat_errors + 16'd1;
            end
        end
    end
`endif

endmodule
